hqm_mem_init_seq: RTL and testbench

Memory initialization sequencer sitting directly downstream of the memory reset synchronizer and in front of a single-port RAM. After reset deassertion it waits a settle interval, then sweeps every RAM address, writing a fixed init value. Only then does it open the RAM to the functional requester. A re-init request repeats the sweep without a reset.

---
 rtl/hqm_mem_init_seq_pkg.sv | 10 +
 rtl/hqm_mem_init_seq.sv | 101 ++++++++++
 tb/tb_hqm_mem_init_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/hqm_mem_init_seq_pkg.sv
// Shared types for the memory init sequencer: FSM state encoding.
package hqm_mem_init_seq_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    INIT   = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hqm_mem_init_seq.sv
// Memory init sequencer: settle after reset, sweep every RAM word with INIT_VAL,
// then hand the RAM port to the functional requester. reinit_req repeats the sweep.
module hqm_mem_init_seq
  import hqm_mem_init_seq_pkg::*;
#(
  parameter int                DEPTH      = 256,
  parameter int                DWIDTH     = 32,
  parameter int                SETTLE_CYC = 4,
  parameter logic [DWIDTH-1:0] INIT_VAL   = '0,
  localparam int               AWIDTH     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reinit_req,
  input  logic              func_we,
  input  logic              func_re,
  input  logic [AWIDTH-1:0] func_addr,
  input  logic [DWIDTH-1:0] func_wdata,
  output logic              func_ready,
  output logic [DWIDTH-1:0] func_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              init_busy,
  output logic              init_done,
  output logic [1:0]        dbg_state
);

  localparam int                SWIDTH      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SWIDTH-1:0] SETTLE_LAST = SWIDTH'(SETTLE_CYC - 1);
  localparam logic [AWIDTH-1:0] ADDR_LAST   = AWIDTH'(DEPTH - 1);

  state_t            state;
  logic [SWIDTH-1:0] settle_cnt;
  logic [AWIDTH-1:0] addr_cnt;

  // Handshake: func_ready high means func_we/func_re/func_addr/func_wdata reach
  // the RAM this same cycle; while low, strobes are dropped and must be held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      addr_cnt   <= '0;
    end else begin
      case (state)
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= INIT;
            settle_cnt <= '0;
            addr_cnt   <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        INIT: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (addr_cnt == ADDR_LAST) state <= DONE;
        end
        DONE: begin
          // Re-init skips the settle interval; this cycle's access still lands.
          if (reinit_req) begin
            state    <= INIT;
            addr_cnt <= '0;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

  // RAM side is a pure decode of state so reset drops strobes without a clock.
  always_comb begin
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = INIT_VAL;
    func_rdata = '0;
    case (state)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = addr_cnt;
      end
      DONE: begin
        mem_we     = func_we;
        mem_re     = func_re;
        mem_addr   = func_addr;
        mem_wdata  = func_wdata;
        func_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

  assign func_ready = (state == DONE);
  assign init_done  = (state == DONE);
  assign init_busy  = (state != DONE);
  assign dbg_state  = state;

endmodule

// File: tb/tb_hqm_mem_init_seq.sv
// Directed bench for hqm_mem_init_seq with DEPTH=8, SETTLE_CYC=4: write scoreboard
// keyed by cycle/address/data plus state-output checks at the documented cycles.
module tb_hqm_mem_init_seq;

  localparam int          DEPTH      = 8;
  localparam int          DWIDTH     = 32;
  localparam int          SETTLE_CYC = 4;
  localparam logic [31:0] IV         = 32'hA5A5_A5A5;
  localparam int          AWIDTH     = 3;

  logic              clk;
  logic              rst;
  logic              reinit_req;
  logic              func_we;
  logic              func_re;
  logic [AWIDTH-1:0] func_addr;
  logic [DWIDTH-1:0] func_wdata;
  logic              func_ready;
  logic [DWIDTH-1:0] func_rdata;
  logic              mem_we;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;
  logic              init_busy;
  logic              init_done;
  logic [1:0]        dbg_state;

  hqm_mem_init_seq #(
    .DEPTH(DEPTH), .DWIDTH(DWIDTH), .SETTLE_CYC(SETTLE_CYC), .INIT_VAL(IV)
  ) dut (
    .clk(clk), .rst(rst), .reinit_req(reinit_req),
    .func_we(func_we), .func_re(func_re), .func_addr(func_addr), .func_wdata(func_wdata),
    .func_ready(func_ready), .func_rdata(func_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_busy(init_busy), .init_done(init_done),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // simple RAM model with combinational read
  logic [DWIDTH-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  // scoreboard: {cycle, addr, data} of every expected RAM write
  logic [50:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_wr(input int c, input int a, input logic [31:0] d);
    exp_q.push_back({16'(c), 3'(a), d});
  endtask

  task automatic push_sweep(input int first_cyc);
    for (int i = 0; i < DEPTH; i++) push_wr(first_cyc + i, i, IV);
  endtask

  // sample the RAM port in the low phase, then advance one cycle
  task automatic tick();
    logic [50:0] e;
    #1;
    if (mem_we === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexp_we cyc=%0d observed addr=%0d data=%0h expected=no write",
               cyc, mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr", {16'(cyc), mem_addr, mem_wdata}, e);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; reinit_req = 1'b0; func_we = 1'b0; func_re = 1'b0;
    func_addr = '0; func_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", init_busy, 1);
    chk("rst_done", init_done, 0);
    chk("rst_ready", func_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_re", mem_re, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, IV);
    chk("rst_rdata", func_rdata, 0);
    chk("rst_state", dbg_state, 0);

    // initial sweep; held func write lands at cycle 12; reinit during INIT ignored
    rst = 1'b0; cyc = 0;
    push_sweep(SETTLE_CYC);
    push_wr(12, 3, 32'h1234);
    while (cyc < 12) begin
      if (cyc == 2) begin func_we = 1'b1; func_addr = 3'd3; func_wdata = 32'h1234; end
      reinit_req = (cyc == 6);
      if (cyc == 8) begin
        func_re = 1'b1; #1;
        chk("busy_rdata", func_rdata, 0);
        chk("busy_re", mem_re, 0);
        chk("busy_ready", func_ready, 0);
        func_re = 1'b0;
      end
      if (cyc == 11) begin #1; chk("done_c11", init_done, 0); end
      tick();
    end
    reinit_req = 1'b0;
    #1;
    chk("done_c12", init_done, 1);
    chk("busy_c12", init_busy, 0);
    chk("ready_c12", func_ready, 1);
    tick();
    func_we = 1'b0;
    func_re = 1'b1; func_addr = 3'd3; #1;
    chk("rd_a3", func_rdata, 32'h1234);
    chk("rd_re", mem_re, 1);
    tick();
    func_re = 1'b0;
    chk("q_empty_a", exp_q.size(), 0);
    while (cyc < 20) tick();

    // reinit together with a functional write: write lands, then sweep overwrites it
    reinit_req = 1'b1; func_we = 1'b1; func_addr = 3'd5; func_wdata = 32'hBEEF;
    push_wr(20, 5, 32'hBEEF);
    push_sweep(21);
    tick();
    reinit_req = 1'b0; func_we = 1'b0;
    #1;
    chk("rei_busy", init_busy, 1);
    chk("rei_done", init_done, 0);
    while (cyc < 29) begin
      if (cyc == 28) begin #1; chk("rei_done_c28", init_done, 0); end
      tick();
    end
    #1;
    chk("rei_done_c29", init_done, 1);
    chk("q_empty_b", exp_q.size(), 0);
    func_re = 1'b1; func_addr = 3'd5; #1;
    chk("rd_a5", func_rdata, IV);
    tick();
    func_re = 1'b0;

    // reset during DONE drops strobes without a clock edge
    func_we = 1'b1; func_addr = 3'd1; func_wdata = 32'h77; #1;
    chk("done_we", mem_we, 1);
    rst = 1'b1; #1;
    chk("arst_we", mem_we, 0);
    chk("arst_ready", func_ready, 0);
    chk("arst_busy", init_busy, 1);
    func_we = 1'b0;
    @(posedge clk); @(negedge clk);

    // reset mid-sweep at cycle 7, then a full restart
    rst = 1'b0; cyc = 0;
    push_wr(4, 0, IV); push_wr(5, 1, IV); push_wr(6, 2, IV);
    while (cyc < 7) tick();
    rst = 1'b1; #1;
    chk("mid_we", mem_we, 0);
    chk("mid_ready", func_ready, 0);
    chk("q_empty_c", exp_q.size(), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc = 0;
    push_sweep(SETTLE_CYC);
    while (cyc < 12) begin
      if (cyc == 11) begin #1; chk("re_done_c11", init_done, 0); end
      tick();
    end
    #1;
    chk("re_done_c12", init_done, 1);
    chk("q_empty_d", exp_q.size(), 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
